// File: rtl/wb_scoreboard_pkg.sv
// ============================================================================
// Module      : wb_scoreboard_pkg
// Description : Shared types and constants for the writeback scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_scoreboard_pkg;

    localparam int SB_DEPTH = 4;

    localparam logic c_CLASS_INT = 1'b0;
    localparam logic c_CLASS_FP  = 1'b1;

    // Packed as {rd, isFp}; the 6-bit value doubles as the pending-counter index.
    typedef struct packed {
        logic [4:0] rd;
        logic       isFp;
    } sb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_sb_counters.sv
// ============================================================================
// Module      : wb_sb_counters
// Description : 2x32 saturating pending-write counters with hazard lookup.
//               WB_SB_BYPASS_EN lets a source matching the retiring entry skip the stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_sb_counters
    import wb_scoreboard_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int CNT_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   incValid,
    input  sb_entry_t              incEntry,
    input  logic                   decValid,
    input  sb_entry_t              decEntry,
    input  logic [DEPTH-1:0]       killMask,
    input  sb_entry_t [DEPTH-1:0]  killEntry,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [4:0]             rs3,
    input  logic                   rs1Fp,
    input  logic                   rs2Fp,
    input  logic                   rs3Fp,
    input  logic [2:0]             rsUse,
    output logic                   stall,
    output logic                   satError
);

    localparam int SW = CNT_W + 2;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0] w_cnt [64];
    logic [63:0]      w_satErr;

    generate
        for (genvar i = 0; i < 64; i++) begin : g_cnt
            localparam sb_entry_t c_IDX = sb_entry_t'(6'(i));
            logic [CNT_W-1:0] r_val;
            logic [SW-1:0]    w_up;
            logic [SW-1:0]    w_dn;
            logic [SW-1:0]    w_res;
            logic             w_err;

            // Net update of one push, one pop and any number of kills in one step.
            always_comb begin
                w_up  = {2'b00, r_val} + SW'(incValid && (incEntry == c_IDX));
                w_dn  = SW'(decValid && (decEntry == c_IDX));
                for (int k = 0; k < DEPTH; k++) begin
                    w_dn = w_dn + SW'(killMask[k] && (killEntry[k] == c_IDX));
                end
                w_err = 1'b0;
                w_res = '0;
                if (w_dn > w_up) begin
                    w_err = 1'b1;
                end else begin
                    w_res = w_up - w_dn;
                    if (w_res > {2'b00, c_CNT_MAX}) begin
                        w_res = {2'b00, c_CNT_MAX};
                        w_err = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_val <= '0;
                end else begin
                    r_val <= w_res[CNT_W-1:0];
                end
            end

            assign w_cnt[i]    = r_val;
            assign w_satErr[i] = w_err;
        end
    endgenerate

    function automatic logic srcPending(input logic [4:0] rs, input logic fp, input logic used);
        logic [5:0] idx;
        logic       pend;
        idx  = {rs, fp};
        pend = used && (w_cnt[idx] != '0) && (fp == c_CLASS_FP || rs != 5'd0);
`ifdef WB_SB_BYPASS_EN
        if (decValid && (decEntry == sb_entry_t'(idx)) && (w_cnt[idx] == CNT_W'(1))) begin
            pend = 1'b0;
        end
`endif
        return pend;
    endfunction

    assign stall = srcPending(rs1, rs1Fp, rsUse[0])
                 | srcPending(rs2, rs2Fp, rsUse[1])
                 | srcPending(rs3, rs3Fp, rsUse[2]);

    assign satError = |w_satErr;

endmodule

`default_nettype wire

// File: rtl/wb_scoreboard.sv
// ============================================================================
// Module      : wb_scoreboard
// Description : In-order tracker of issued-but-unretired int/fp register writes
//               driving the ID-stage RAW stall. Optional macro: WB_SB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int CNT_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic [4:0]                 issue_rd,
    input  logic                       issue_wbEnable,
    input  logic                       issue_fwbEnable,
    output logic                       issue_ready,
    input  logic                       WB_valid,
    input  logic [4:0]                 WB_rd,
    input  logic                       WB_wbEnable,
    input  logic                       WB_fwbEnable,
    input  logic                       kill_valid,
    input  logic [$clog2(DEPTH):0]     kill_cnt,
    input  logic [4:0]                 ID_rs1,
    input  logic [4:0]                 ID_rs2,
    input  logic [4:0]                 ID_rs3,
    input  logic                       ID_rs1Fp,
    input  logic                       ID_rs2Fp,
    input  logic                       ID_rs3Fp,
    input  logic [2:0]                 ID_rsUse,
    output logic                       ID_stall,
    output logic [$clog2(DEPTH):0]     inflight,
    output logic                       sb_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    sb_entry_t        r_queue [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [OW-1:0]    r_count;
    logic             r_sbError;

    sb_entry_t             w_pushEntry;
    sb_entry_t             w_wbEntry;
    logic                  w_pushReq;
    logic                  w_pushEnq;
    logic                  w_pushErr;
    logic                  w_popReq;
    logic                  w_pop;
    logic                  w_popErr;
    logic                  w_satErr;
    logic [OW-1:0]         w_avail;
    logic [OW-1:0]         w_killN;
    logic [PW-1:0]         w_tailKilled;
    logic [DEPTH-1:0]      w_killMask;
    sb_entry_t [DEPTH-1:0] w_killEntry;

    always_comb begin
        w_pushEntry.rd   = issue_rd;
        w_pushEntry.isFp = issue_fwbEnable ? c_CLASS_FP : c_CLASS_INT;
        w_wbEntry.rd     = WB_rd;
        w_wbEntry.isFp   = WB_fwbEnable ? c_CLASS_FP : c_CLASS_INT;

        w_popReq = WB_valid && (WB_wbEnable || WB_fwbEnable)
                 && !(w_wbEntry.isFp == c_CLASS_INT && WB_rd == 5'd0);
        w_pop    = w_popReq && (r_count != '0);
        w_popErr = w_popReq && ((r_count == '0) || (r_queue[r_head] != w_wbEntry));

        issue_ready = (r_count < OW'(DEPTH)) || w_pop;

        w_pushReq = issue_valid && (issue_wbEnable || issue_fwbEnable) && issue_ready;
        w_pushErr = w_pushReq && issue_wbEnable && issue_fwbEnable;
        w_pushEnq = w_pushReq && !(w_pushEntry.isFp == c_CLASS_INT && issue_rd == 5'd0);

        // Kill sees the queue after this cycle's pop, before this cycle's push.
        w_avail = r_count - OW'(w_pop);
        w_killN = '0;
        if (kill_valid) begin
            w_killN = (kill_cnt < w_avail) ? kill_cnt : w_avail;
        end
        w_tailKilled = r_tail - w_killN[PW-1:0];
    end

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_kill
            assign w_killMask[k]  = (OW'(k) < w_killN);
            assign w_killEntry[k] = r_queue[r_tail - PW'(k + 1)];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_sbError <= 1'b0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_tail  <= w_tailKilled + PW'(w_pushEnq);
            r_count <= w_avail - w_killN + OW'(w_pushEnq);
            if (w_popErr || w_pushErr || w_satErr) begin
                r_sbError <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_pushEnq) begin
            r_queue[w_tailKilled] <= w_pushEntry;
        end
    end

    wb_sb_counters #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_counters (
        .clk       (clk),
        .rst       (rst),
        .incValid  (w_pushEnq),
        .incEntry  (w_pushEntry),
        .decValid  (w_pop),
        .decEntry  (r_queue[r_head]),
        .killMask  (w_killMask),
        .killEntry (w_killEntry),
        .rs1       (ID_rs1),
        .rs2       (ID_rs2),
        .rs3       (ID_rs3),
        .rs1Fp     (ID_rs1Fp),
        .rs2Fp     (ID_rs2Fp),
        .rs3Fp     (ID_rs3Fp),
        .rsUse     (ID_rsUse),
        .stall     (ID_stall),
        .satError  (w_satErr)
    );

    assign inflight = r_count;
    assign sb_error = r_sbError;

endmodule

`default_nettype wire

// File: tb/tb_wb_scoreboard.sv
// ============================================================================
// Module      : tb_wb_scoreboard
// Description : Directed self-checking bench for wb_scoreboard (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_scoreboard;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_wbEnable;
    logic       issue_fwbEnable;
    logic       issue_ready;
    logic       WB_valid;
    logic [4:0] WB_rd;
    logic       WB_wbEnable;
    logic       WB_fwbEnable;
    logic       kill_valid;
    logic [2:0] kill_cnt;
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic [4:0] ID_rs3;
    logic       ID_rs1Fp;
    logic       ID_rs2Fp;
    logic       ID_rs3Fp;
    logic [2:0] ID_rsUse;
    logic       ID_stall;
    logic [2:0] inflight;
    logic       sb_error;

    int nChecks = 0;
    int nErrors = 0;

`ifdef WB_SB_BYPASS_EN
    localparam logic c_POP_STALL = 1'b0;
`else
    localparam logic c_POP_STALL = 1'b1;
`endif

    wb_scoreboard #(.DEPTH(4), .CNT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_wbEnable  (issue_wbEnable),
        .issue_fwbEnable (issue_fwbEnable),
        .issue_ready     (issue_ready),
        .WB_valid        (WB_valid),
        .WB_rd           (WB_rd),
        .WB_wbEnable     (WB_wbEnable),
        .WB_fwbEnable    (WB_fwbEnable),
        .kill_valid      (kill_valid),
        .kill_cnt        (kill_cnt),
        .ID_rs1          (ID_rs1),
        .ID_rs2          (ID_rs2),
        .ID_rs3          (ID_rs3),
        .ID_rs1Fp        (ID_rs1Fp),
        .ID_rs2Fp        (ID_rs2Fp),
        .ID_rs3Fp        (ID_rs3Fp),
        .ID_rsUse        (ID_rsUse),
        .ID_stall        (ID_stall),
        .inflight        (inflight),
        .sb_error        (sb_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIssue(input logic v, input logic [4:0] rd, input logic fp);
        issue_valid     = v;
        issue_rd        = rd;
        issue_wbEnable  = v && !fp;
        issue_fwbEnable = v && fp;
    endtask

    task automatic setWb(input logic v, input logic [4:0] rd, input logic fp);
        WB_valid     = v;
        WB_rd        = rd;
        WB_wbEnable  = v && !fp;
        WB_fwbEnable = v && fp;
    endtask

    task automatic setSrc(input logic [4:0] rs, input logic fp, input logic [2:0] use_);
        ID_rs1 = rs; ID_rs2 = rs; ID_rs3 = rs;
        ID_rs1Fp = fp; ID_rs2Fp = fp; ID_rs3Fp = fp;
        ID_rsUse = use_;
    endtask

    task automatic push(input logic [4:0] rd, input logic fp);
        setIssue(1'b1, rd, fp);
        tick();
        setIssue(1'b0, 5'd0, 1'b0);
    endtask

    task automatic pop(input logic [4:0] rd, input logic fp);
        setWb(1'b1, rd, fp);
        tick();
        setWb(1'b0, 5'd0, 1'b0);
    endtask

    task automatic probe(input string tag, input logic [4:0] rs, input logic fp, input logic exp);
        setSrc(rs, fp, 3'b001);
        #1;
        chk(tag, 32'(ID_stall), 32'(exp));
    endtask

    initial begin
        rst = 1'b0;
        setIssue(1'b0, 5'd0, 1'b0);
        setWb(1'b0, 5'd0, 1'b0);
        kill_valid = 1'b0;
        kill_cnt   = 3'd0;
        setSrc(5'd0, 1'b0, 3'b000);
        tick();
        tick();
        chk("rst_ready", 32'(issue_ready), 1);
        chk("rst_stall", 32'(ID_stall), 0);
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_err", 32'(sb_error), 0);
        rst = 1'b1;
        tick();

        // Basic RAW on x5
        push(5'd5, 1'b0);
        probe("raw_x5", 5'd5, 1'b0, 1'b1);
        chk("raw_inflight", 32'(inflight), 1);
        setWb(1'b1, 5'd5, 1'b0);
        #1;
        chk("pop_cycle_stall", 32'(ID_stall), 32'(c_POP_STALL));
        tick();
        setWb(1'b0, 5'd0, 1'b0);
        probe("after_pop_stall", 5'd5, 1'b0, 1'b0);
        chk("after_pop_inflight", 32'(inflight), 0);

        // Class separation and x0
        push(5'd3, 1'b0);
        push(5'd7, 1'b1);
        probe("int3_as_fp", 5'd3, 1'b1, 1'b0);
        probe("int3_as_int", 5'd3, 1'b0, 1'b1);
        probe("fp7_as_fp", 5'd7, 1'b1, 1'b1);
        probe("fp7_as_int", 5'd7, 1'b0, 1'b0);
        setSrc(5'd7, 1'b1, 3'b100);
        #1;
        chk("rs3_used", 32'(ID_stall), 1);
        setSrc(5'd7, 1'b1, 3'b000);
        #1;
        chk("rs_unused", 32'(ID_stall), 0);
        push(5'd0, 1'b0);
        chk("x0_inflight", 32'(inflight), 2);
        probe("x0_stall", 5'd0, 1'b0, 1'b0);
        pop(5'd3, 1'b0);
        pop(5'd7, 1'b1);
        chk("drain1_inflight", 32'(inflight), 0);
        chk("drain1_err", 32'(sb_error), 0);

        // Full queue, simultaneous pop+push, wrap and in-order retire
        push(5'd10, 1'b0);
        push(5'd11, 1'b0);
        push(5'd12, 1'b0);
        push(5'd13, 1'b0);
        chk("full_ready", 32'(issue_ready), 0);
        chk("full_inflight", 32'(inflight), 4);
        setIssue(1'b1, 5'd14, 1'b0);
        setWb(1'b1, 5'd10, 1'b0);
        #1;
        chk("full_pop_ready", 32'(issue_ready), 1);
        tick();
        setIssue(1'b0, 5'd0, 1'b0);
        setWb(1'b0, 5'd0, 1'b0);
        #1;
        chk("swap_inflight", 32'(inflight), 4);
        chk("swap_ready", 32'(issue_ready), 0);
        probe("x10_retired", 5'd10, 1'b0, 1'b0);
        probe("x14_pending", 5'd14, 1'b0, 1'b1);
        pop(5'd11, 1'b0);
        pop(5'd12, 1'b0);
        pop(5'd13, 1'b0);
        probe("x14_still", 5'd14, 1'b0, 1'b1);
        pop(5'd14, 1'b0);
        chk("wrap_inflight", 32'(inflight), 0);
        chk("wrap_err", 32'(sb_error), 0);

        // Push and pop the same register in one cycle
        push(5'd20, 1'b0);
        setIssue(1'b1, 5'd20, 1'b0);
        setWb(1'b1, 5'd20, 1'b0);
        tick();
        setIssue(1'b0, 5'd0, 1'b0);
        setWb(1'b0, 5'd0, 1'b0);
        probe("same_reg_stall", 5'd20, 1'b0, 1'b1);
        chk("same_reg_inflight", 32'(inflight), 1);
        pop(5'd20, 1'b0);
        probe("same_reg_clear", 5'd20, 1'b0, 1'b0);
        chk("same_reg_err", 32'(sb_error), 0);

        // Kill youngest entries
        push(5'd7, 1'b0);
        push(5'd8, 1'b0);
        push(5'd9, 1'b0);
        kill_valid = 1'b1;
        kill_cnt   = 3'd2;
        tick();
        kill_valid = 1'b0;
        chk("kill2_inflight", 32'(inflight), 1);
        probe("kill_x8", 5'd8, 1'b0, 1'b0);
        probe("kill_x9", 5'd9, 1'b0, 1'b0);
        probe("kill_x7", 5'd7, 1'b0, 1'b1);
        kill_valid = 1'b1;
        kill_cnt   = 3'd5;
        tick();
        kill_valid = 1'b0;
        chk("kill5_inflight", 32'(inflight), 0);
        chk("kill5_err", 32'(sb_error), 0);
        probe("kill5_x7", 5'd7, 1'b0, 1'b0);

        // Kill and push in the same cycle
        push(5'd1, 1'b0);
        push(5'd2, 1'b0);
        kill_valid = 1'b1;
        kill_cnt   = 3'd1;
        setIssue(1'b1, 5'd3, 1'b0);
        tick();
        kill_valid = 1'b0;
        setIssue(1'b0, 5'd0, 1'b0);
        chk("killpush_inflight", 32'(inflight), 2);
        probe("killpush_x2", 5'd2, 1'b0, 1'b0);
        probe("killpush_x3", 5'd3, 1'b0, 1'b1);
        pop(5'd1, 1'b0);
        pop(5'd3, 1'b0);
        chk("killpush_err", 32'(sb_error), 0);

        // Same-cycle pop against rs2
        push(5'd4, 1'b0);
        setSrc(5'd4, 1'b0, 3'b010);
        setWb(1'b1, 5'd4, 1'b0);
        #1;
        chk("bypass_rs2", 32'(ID_stall), 32'(c_POP_STALL));
        tick();
        setWb(1'b0, 5'd0, 1'b0);
        #1;
        chk("bypass_after", 32'(ID_stall), 0);

        // Protocol errors and mid-stream reset
        pop(5'd6, 1'b0);
        chk("empty_pop_err", 32'(sb_error), 1);
        chk("empty_pop_inflight", 32'(inflight), 0);
        tick();
        chk("err_sticky", 32'(sb_error), 1);
        push(5'd9, 1'b0);
        push(5'd10, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_inflight", 32'(inflight), 0);
        chk("midrst_err", 32'(sb_error), 0);
        chk("midrst_ready", 32'(issue_ready), 1);
        probe("midrst_x9", 5'd9, 1'b0, 1'b0);
        push(5'd9, 1'b0);
        pop(5'd8, 1'b0);
        chk("mismatch_err", 32'(sb_error), 1);
        chk("mismatch_inflight", 32'(inflight), 0);
        push(5'd12, 1'b1);
        setIssue(1'b1, 5'd13, 1'b0);
        issue_fwbEnable = 1'b1;
        tick();
        setIssue(1'b0, 5'd0, 1'b0);
        probe("both_en_fp", 5'd13, 1'b1, 1'b1);
        probe("both_en_int", 5'd13, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule

`default_nettype wire
